// File: rtl/bpu_gshare.sv
// bpu_gshare: fetch-stage branch predictor.
// Predicts one fetch group per cycle from a tagged BTB and a gshare PHT
// (PC xor speculative global history). Resolved branches train both tables
// and restore history on a misprediction.
// Optional feature: define BPU_RAS_EN to add a circular return address stack.
module bpu_gshare #(
  parameter int FETCH_W   = 4,
  parameter int BTB_IDX   = 6,
  parameter int TAG_W     = 10,
  parameter int GHR_W     = 8,
  parameter int RAS_DEPTH = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [31:0]        fs_pc,
  input  logic               fs_req,
  output logic [31:0]        next_pc,
  output logic [FETCH_W-1:0] pc_valid,
  output logic [FETCH_W-1:0] pc_is_jump,
  output logic [GHR_W-1:0]   pred_ghr,
  input  logic               upd_valid,
  input  logic [31:0]        upd_pc,
  input  logic               upd_taken,
  input  logic [31:0]        upd_target,
  input  logic [1:0]         upd_type,
  input  logic [GHR_W-1:0]   upd_ghr,
  input  logic               upd_mispred,
  input  logic               flush
);

  localparam int SLOT_B = $clog2(FETCH_W);
  localparam int BTB_N  = 1 << BTB_IDX;
  localparam int PHT_N  = 1 << GHR_W;
  // Highest PC bit any table lookup needs.
  localparam int PC_HI  = (BTB_IDX + TAG_W + 1 > GHR_W + 1) ? BTB_IDX + TAG_W + 1 : GHR_W + 1;

  localparam logic [1:0] T_COND = 2'b00;
  localparam logic [1:0] T_CALL = 2'b10;
  localparam logic [1:0] T_RET  = 2'b11;

  logic [BTB_N-1:0]   btb_valid_q;
  logic [1:0]         btb_type_q [BTB_N];
  logic [TAG_W-1:0]   btb_tag_q  [BTB_N];
  logic [29:0]        btb_tgt_q  [BTB_N];
  logic [1:0]         pht_q      [PHT_N];
  logic [GHR_W-1:0]   ghr_q, ghr_d;

  logic [31:0]        grp_base;
  logic               found;
  logic [SLOT_B-1:0]  win_slot;
  logic [1:0]         win_type;
  logic [29:0]        win_tgt;
  logic               cond_seen;
  logic               spec_en;
  logic               ras_nonempty;
  logic [31:0]        ras_top;

  // Scan the live slots in order; the first predicted-taken hit wins.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin : predict
    logic [PC_HI:2]     slot_pc;
    logic [BTB_IDX-1:0] idx;
    logic [GHR_W-1:0]   pidx;
    logic               live;
    logic               hit;
    grp_base   = {fs_pc[31:SLOT_B+2], {(SLOT_B+2){1'b0}}};
    found      = 1'b0;
    win_slot   = '0;
    win_type   = '0;
    win_tgt    = '0;
    cond_seen  = 1'b0;
    pc_valid   = '0;
    pc_is_jump = '0;
    slot_pc    = '0;
    idx        = '0;
    pidx       = '0;
    live       = 1'b0;
    hit        = 1'b0;
    for (int s = 0; s < FETCH_W; s++) begin
      slot_pc = {fs_pc[PC_HI:SLOT_B+2], SLOT_B'(s)};
      idx     = slot_pc[BTB_IDX+1:2];
      pidx    = slot_pc[GHR_W+1:2] ^ ghr_q;
      live    = SLOT_B'(s) >= fs_pc[SLOT_B+1:2];
      hit     = live && btb_valid_q[idx] &&
                (btb_tag_q[idx] == slot_pc[BTB_IDX+TAG_W+1:BTB_IDX+2]);
      pc_valid[s] = live && !found;
      if (!found && hit) begin
        if (btb_type_q[idx] == T_COND) cond_seen = 1'b1;
        if (btb_type_q[idx] != T_COND || pht_q[pidx][1]) begin
          found         = 1'b1;
          win_slot      = SLOT_B'(s);
          win_type      = btb_type_q[idx];
          win_tgt       = btb_tgt_q[idx];
          pc_is_jump[s] = 1'b1;
        end
      end
    end
  end

  // Redirect to the winner's target (RAS top for a return), else fall through.
  always_comb begin
    next_pc = grp_base + 32'(4 * FETCH_W);
    if (found) next_pc = (win_type == T_RET && ras_nonempty) ? ras_top : {win_tgt, 2'b00};
  end

  assign pred_ghr = ghr_q;
  assign spec_en  = fs_req && !flush && !upd_mispred;

  // History: one bit per accepted group, overridden by a mispredict restore.
  always_comb begin
    ghr_d = ghr_q;
    if (spec_en && cond_seen) ghr_d = {ghr_q[GHR_W-2:0], found && win_type == T_COND};
    if (upd_valid && upd_mispred)
      ghr_d = (upd_type == T_COND) ? {upd_ghr[GHR_W-2:0], upd_taken} : upd_ghr;
  end

  logic [BTB_IDX-1:0] u_idx;
  logic [GHR_W-1:0]   u_pidx;
  logic               u_hit;
  assign u_idx  = upd_pc[BTB_IDX+1:2];
  assign u_pidx = upd_pc[GHR_W+1:2] ^ upd_ghr;
  assign u_hit  = btb_valid_q[u_idx] && (btb_tag_q[u_idx] == upd_pc[BTB_IDX+TAG_W+1:BTB_IDX+2]);

  // Valid bits, PHT counters and history: cleared asynchronously, trained on update.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btb_valid_q <= '0;
      ghr_q       <= '0;
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
    end else begin
      ghr_q <= ghr_d;
      if (upd_valid) begin
        if (upd_taken) begin
          btb_valid_q[u_idx] <= 1'b1;
          if (u_hit) pht_q[u_pidx] <= (pht_q[u_pidx] == 2'b11) ? 2'b11 : pht_q[u_pidx] + 2'b01;
          else       pht_q[u_pidx] <= 2'b10;
        end else begin
          pht_q[u_pidx] <= (pht_q[u_pidx] == 2'b00) ? 2'b00 : pht_q[u_pidx] - 2'b01;
        end
      end
    end
  end

  // BTB payload is written on every taken update (allocate or refresh).
  // NOTE: payload arrays have no reset; the valid bits gate every read.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      btb_type_q[u_idx] <= upd_type;
      btb_tag_q[u_idx]  <= upd_pc[BTB_IDX+TAG_W+1:BTB_IDX+2];
      btb_tgt_q[u_idx]  <= upd_target[31:2];
    end
  end

`ifdef BPU_RAS_EN
  localparam int RAS_B = $clog2(RAS_DEPTH);

  logic [31:0]      ras_q [RAS_DEPTH];
  logic [RAS_B-1:0] ras_ptr_q;
  logic [RAS_B:0]   ras_cnt_q;
  logic             ras_push, ras_pop;
  logic [31:0]      ras_push_pc;

  assign ras_nonempty = ras_cnt_q != '0;
  assign ras_top      = ras_q[ras_ptr_q - RAS_B'(1)];
  assign ras_push     = spec_en && found && win_type == T_CALL;
  assign ras_pop      = spec_en && found && win_type == T_RET && ras_nonempty;
  assign ras_push_pc  = grp_base + 32'({win_slot, 2'b00}) + 32'd4;

  // Pointer and occupancy; a full stack wraps over its oldest entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else if (ras_push) begin
      ras_ptr_q <= ras_ptr_q + RAS_B'(1);
      if (ras_cnt_q != (RAS_B+1)'(RAS_DEPTH)) ras_cnt_q <= ras_cnt_q + (RAS_B+1)'(1);
    end else if (ras_pop) begin
      ras_ptr_q <= ras_ptr_q - RAS_B'(1);
      ras_cnt_q <= ras_cnt_q - (RAS_B+1)'(1);
    end
  end

  // Return address storage.
  always_ff @(posedge clk) begin
    if (ras_push) ras_q[ras_ptr_q] <= ras_push_pc;
  end
`else
  assign ras_nonempty = 1'b0;
  assign ras_top      = '0;
  logic unused_ras;
  assign unused_ras = ^{win_slot, 32'(RAS_DEPTH)};
`endif

  // PC bits below word alignment and above the table fields are don't-care.
  logic unused_bits;
  assign unused_bits = ^{fs_pc, upd_pc, upd_target};

endmodule

// File: tb/tb_bpu_gshare.sv
// tb_bpu_gshare: table-driven reset vectors, directed corner sequences and
// randomized traffic compared every cycle against a behavioural model.
// Build with +define+BPU_RAS_EN to cover the return address stack.
module tb_bpu_gshare;
  localparam int FW = 4, BI = 6, TW = 10, GW = 8, RD = 8;
`ifdef BPU_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] fs_pc;
  logic        fs_req;
  logic [31:0] next_pc;
  logic [FW-1:0] pc_valid, pc_is_jump;
  logic [GW-1:0] pred_ghr;
  logic        upd_valid, upd_taken, upd_mispred, flush;
  logic [31:0] upd_pc, upd_target;
  logic [1:0]  upd_type;
  logic [GW-1:0] upd_ghr;

  bpu_gshare #(.FETCH_W(FW), .BTB_IDX(BI), .TAG_W(TW), .GHR_W(GW), .RAS_DEPTH(RD)) dut (
    .clk(clk), .resetn(resetn), .fs_pc(fs_pc), .fs_req(fs_req), .next_pc(next_pc),
    .pc_valid(pc_valid), .pc_is_jump(pc_is_jump), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_type(upd_type), .upd_ghr(upd_ghr), .upd_mispred(upd_mispred), .flush(flush)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { bit v; bit [1:0] typ; bit [9:0] tag; bit [31:0] tgt; } btb_t;
  btb_t        m_btb [64];
  bit [1:0]    m_pht [256];
  bit [7:0]    m_ghr;
  bit [31:0]   m_ras [$];

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_btb[i] = '{default: '0};
    for (int i = 0; i < 256; i++) m_pht[i] = 2'd1;
    m_ghr = '0;
    m_ras.delete();
  endtask

  function automatic void m_predict(input logic [31:0] pc, output logic [31:0] npc,
                                    output logic [3:0] vld, output logic [3:0] jmp,
                                    output int win, output logic [1:0] wtyp, output bit cseen);
    logic [31:0] base, spc;
    btb_t e;
    base  = pc & ~32'hF;
    npc   = base + 32'd16;
    vld   = '0;
    jmp   = '0;
    win   = -1;
    wtyp  = '0;
    cseen = 1'b0;
    for (int s = int'(pc[3:2]); s < FW; s++) begin
      spc = base + 32'(4 * s);
      e = m_btb[6'(spc >> 2)];
      vld[s] = 1'b1;
      if (e.v && e.tag == spc[17:8]) begin
        if (e.typ == 2'd0) cseen = 1'b1;
        if (e.typ != 2'd0 || m_pht[8'(spc >> 2) ^ m_ghr] >= 2'd2) begin
          win = s;
          wtyp = e.typ;
          jmp[s] = 1'b1;
          npc = (e.typ == 2'd3 && RAS_ON && m_ras.size() > 0) ? m_ras[$] : e.tgt;
          break;
        end
      end
    end
  endfunction

  task automatic m_clock();
    logic [31:0] npc;
    logic [3:0]  vld, jmp;
    int          win;
    logic [1:0]  wtyp;
    bit          cseen, spec, hit;
    bit [7:0]    ng, p;
    bit [5:0]    ix;
    m_predict(fs_pc, npc, vld, jmp, win, wtyp, cseen);
    spec = fs_req && !flush && !upd_mispred;
    ng = m_ghr;
    if (spec && cseen) ng = {m_ghr[6:0], (win >= 0 && wtyp == 2'd0)};
    if (spec && win >= 0 && RAS_ON) begin
      if (wtyp == 2'd2) begin
        m_ras.push_back((fs_pc & ~32'hF) + 32'(4 * win) + 32'd4);
        if (m_ras.size() > RD) void'(m_ras.pop_front());
      end else if (wtyp == 2'd3 && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
    if (upd_valid && upd_mispred) ng = (upd_type == 2'd0) ? {upd_ghr[6:0], upd_taken} : upd_ghr;
    if (upd_valid) begin
      ix  = 6'(upd_pc >> 2);
      p   = 8'(upd_pc >> 2) ^ upd_ghr;
      hit = m_btb[ix].v && m_btb[ix].tag == upd_pc[17:8];
      if (upd_taken) begin
        m_btb[ix] = '{1'b1, upd_type, upd_pc[17:8], upd_target & ~32'h3};
        if (!hit) m_pht[p] = 2'd2;
        else if (m_pht[p] != 2'd3) m_pht[p] = m_pht[p] + 2'd1;
      end else if (m_pht[p] != 2'd0) begin
        m_pht[p] = m_pht[p] - 2'd1;
      end
    end
    m_ghr = ng;
  endtask

  // Compare all outputs to the model, then clock DUT and model together.
  task automatic cycle();
    logic [31:0] npc;
    logic [3:0]  vld, jmp;
    int          win;
    logic [1:0]  wtyp;
    bit          cseen;
    #1;
    m_predict(fs_pc, npc, vld, jmp, win, wtyp, cseen);
    check("next_pc", next_pc, npc);
    check("pc_valid", 32'(pc_valid), 32'(vld));
    check("pc_is_jump", 32'(pc_is_jump), 32'(jmp));
    check("pred_ghr", 32'(pred_ghr), 32'(m_ghr));
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic idle();
    fs_req = 0; flush = 0; upd_valid = 0; upd_mispred = 0; upd_taken = 0;
    upd_pc = '0; upd_target = '0; upd_type = '0; upd_ghr = '0;
  endtask

  task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic [1:0] typ);
    fs_req = 0; upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_type = typ; upd_ghr = m_ghr; upd_mispred = 0;
    cycle();
    upd_valid = 0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic req);
    fs_pc = pc; fs_req = req;
    cycle();
    fs_req = 0;
  endtask

  typedef struct { logic [31:0] pc; logic [31:0] nxt; logic [3:0] vld; } vec_t;
  vec_t vt [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] want;
    vt[0] = '{32'h1C000008, 32'h1C000010, 4'b1100};
    vt[1] = '{32'h1C000000, 32'h1C000010, 4'b1111};
    vt[2] = '{32'h1C00000C, 32'h1C000010, 4'b1000};
    vt[3] = '{32'hFFFFFFF4, 32'h00000000, 4'b1110};

    resetn = 0; fs_pc = 32'h1C000008; idle(); m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1;
    @(posedge clk); #1;

    // Empty tables: sequential prediction and live-slot masks.
    foreach (vt[i]) begin
      fs_pc = vt[i].pc;
      #1;
      check("rst_next_pc", next_pc, vt[i].nxt);
      check("rst_pc_valid", 32'(pc_valid), 32'(vt[i].vld));
      check("rst_pc_is_jump", 32'(pc_is_jump), 32'd0);
      check("rst_pred_ghr", 32'(pred_ghr), 32'd0);
    end

    // Conditional trained taken, then predicted from its group.
    train(32'h1C000004, 1'b1, 32'h1C000100, 2'b00);
    fs_pc = 32'h1C000000; fs_req = 1; #1;
    check("cond_jump", 32'(pc_is_jump), 32'b0010);
    check("cond_valid", 32'(pc_valid), 32'b0011);
    check("cond_next", next_pc, 32'h1C000100);
    cycle(); fs_req = 0;
    check("cond_ghr", 32'(pred_ghr), 32'h01);

    // Two not-taken outcomes drop the prediction to sequential.
    train(32'h1C000004, 1'b0, 32'h1C000100, 2'b00);
    train(32'h1C000004, 1'b0, 32'h1C000100, 2'b00);
    fs_pc = 32'h1C000000; #1;
    check("nt_next", next_pc, 32'h1C000010);
    cycle();

    // Mispredict restore beats a same-cycle speculative shift.
    train(32'h1C000004, 1'b1, 32'h1C000100, 2'b00);
    train(32'h1C000004, 1'b1, 32'h1C000100, 2'b00);
    fs_pc = 32'h1C000000; fs_req = 1; #1;
    check("mp_spec_jump", 32'(pc_is_jump), 32'b0010);
    upd_valid = 1; upd_mispred = 1; upd_type = 2'b00; upd_ghr = 8'hA5; upd_taken = 1;
    upd_pc = 32'h1C000040; upd_target = 32'h1C000080;
    cycle(); idle();
    check("mp_ghr", 32'(pred_ghr), 32'h4B);
    // Flush blocks the speculative shift; the following group shifts a 0.
    fs_pc = 32'h1C000000; fs_req = 1; flush = 1;
    cycle(); flush = 0;
    check("flush_ghr", 32'(pred_ghr), 32'h4B);
    cycle(); fs_req = 0;
    check("shift0_ghr", 32'(pred_ghr), 32'h96);

    // Call then return.
    train(32'h1C000008, 1'b1, 32'h1C000200, 2'b10);
    train(32'h1C000200, 1'b1, 32'h1C000300, 2'b11);
    fs_pc = 32'h1C000008; fs_req = 1; #1;
    check("call_next", next_pc, 32'h1C000200);
    check("call_jump", 32'(pc_is_jump), 32'b0100);
    cycle();
    fs_pc = 32'h1C000200; #1;
    check("ret_next", next_pc, RAS_ON ? 32'h1C00000C : 32'h1C000300);
    cycle(); fs_req = 0;

    // Nine calls overflow an eight-deep stack; nine returns follow.
    for (int k = 0; k < 9; k++) train(32'h1C000420 + 32'(16 * k), 1'b1, 32'h1C000600, 2'b10);
    for (int k = 0; k < 9; k++) fetch(32'h1C000420 + 32'(16 * k), 1'b1);
    for (int j = 0; j < 9; j++) begin
      fs_pc = 32'h1C000200; fs_req = 1; #1;
      want = (RAS_ON && j < 8) ? 32'h1C000424 + 32'(16 * (8 - j)) : 32'h1C000300;
      check("ras_chain_next", next_pc, want);
      cycle();
    end
    idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      fs_pc       = 32'h1C000000 + ($urandom_range(0, 127) << 2);
      fs_req      = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 7) == 0);
      upd_valid   = ($urandom_range(0, 2) == 0);
      upd_pc      = 32'h1C000000 + ($urandom_range(0, 127) << 2);
      upd_taken   = ($urandom_range(0, 1) != 0);
      upd_target  = 32'h1C000000 + ($urandom_range(0, 255) << 2);
      upd_type    = 2'($urandom_range(0, 3));
      upd_ghr     = ($urandom_range(0, 1) != 0) ? m_ghr : 8'($urandom);
      upd_mispred = upd_valid && ($urandom_range(0, 5) == 0);
      cycle();
    end
    idle();

    // Asynchronous reset between edges clears the BTB immediately.
    train(32'h1C000004, 1'b1, 32'h1C000100, 2'b01);
    fs_pc = 32'h1C000000; #1;
    check("pre_rst_next", next_pc, 32'h1C000100);
    #2 resetn = 0;
    #1;
    check("async_rst_next", next_pc, 32'h1C000010);
    check("async_rst_jump", 32'(pc_is_jump), 32'd0);
    check("async_rst_ghr", 32'(pred_ghr), 32'd0);
    m_reset();
    @(posedge clk);
    @(negedge clk) resetn = 1;
    @(posedge clk); #1;
    fs_pc = 32'h1C000000; fs_req = 1; #1;
    check("post_rst_next", next_pc, 32'h1C000010);
    cycle(); fs_req = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
